// File: rtl/hc_tx_port_arb_n.sv
// hc_tx_port_arb_n: grants one of NUM_CH channels ownership of a shared
// TX port and muxes the owner's wen/data/cntl onto that port.
//
// Parameters:
//   NUM_CH     number of requesting channels (2..8)
//   DATA_W     width of each channel's data field
//   CNTL_W     width of each channel's control field
//   RR_MODE    0 = fixed priority (lowest index wins), 1 = round-robin
//   GAP_CYCLES idle cycles forced after each release (0..15)
//
// Ports:
//   clk        clock, all state changes on the rising edge
//   rst        synchronous active-high reset
//   req        per-channel request, bit i is channel i
//   wen        per-channel write enable
//   data       channel i at [i*DATA_W +: DATA_W]
//   cntl       channel i at [i*CNTL_W +: CNTL_W]
//   gnt        registered one-hot-or-zero grant
//   port_wen   write enable of the owning channel (0 when idle)
//   port_data  data of the owning channel (0 when idle)
//   port_cntl  control of the owning channel (0 when idle)
//   sel_idx    registered index of the owner, 0 when no owner
//   busy       registered, high while a grant is held

module hc_tx_port_arb_n #(
    parameter int NUM_CH     = 3,
    parameter int DATA_W     = 8,
    parameter int CNTL_W     = 8,
    parameter int RR_MODE    = 0,
    parameter int GAP_CYCLES = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH-1:0]        req,
    input  logic [NUM_CH-1:0]        wen,
    input  logic [NUM_CH*DATA_W-1:0] data,
    input  logic [NUM_CH*CNTL_W-1:0] cntl,
    output logic [NUM_CH-1:0]        gnt,
    output logic                     port_wen,
    output logic [DATA_W-1:0]        port_data,
    output logic [CNTL_W-1:0]        port_cntl,
    output logic [2:0]               sel_idx,
    output logic                     busy
);

    typedef enum logic [1:0] {
        INIT,
        IDLE,
        GRANT,
        GAP
    } stateT;

    stateT             state;
    stateT             stateNext;
    logic [NUM_CH-1:0] gntQ;
    logic [NUM_CH-1:0] gntNext;
    logic [2:0]        selQ;
    logic [2:0]        selNext;
    logic              busyQ;
    logic              busyNext;
    logic [3:0]        gapCnt;
    logic [3:0]        gapNext;
    logic [2:0]        lastOwner;
    logic [2:0]        lastNext;

    logic [2:0]        winIdx;
    logic              found;
    logic              ownerReq;
    int                cand;

    // Winner selection. Only consumed when req != 0, so the value
    // produced for an all-zero req is irrelevant.
    always_comb begin
        winIdx = '0;
        found  = 1'b0;
        cand   = 0;
        if (RR_MODE != 0) begin
            // Walk outward from the channel after the last owner;
            // one subtraction is enough since cand < 2*NUM_CH.
            for (int k = 0; k < NUM_CH; k++) begin
                cand = int'(lastOwner) + 1 + k;
                if (cand >= NUM_CH) begin
                    cand = cand - NUM_CH;
                end
                for (int i = 0; i < NUM_CH; i++) begin
                    if (!found && cand == i && req[i]) begin
                        winIdx = 3'(i);
                        found  = 1'b1;
                    end
                end
            end
        end else begin
            // Descending scan so the lowest set bit is written last.
            for (int i = NUM_CH - 1; i >= 0; i--) begin
                if (req[i]) begin
                    winIdx = 3'(i);
                    found  = 1'b1;
                end
            end
        end
    end

    // Request line of the current owner; only req[owner] can end a grant.
    always_comb begin
        ownerReq = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (selQ == 3'(i)) begin
                ownerReq = req[i];
            end
        end
    end

    always_comb begin
        stateNext = state;
        gntNext   = gntQ;
        selNext   = selQ;
        busyNext  = busyQ;
        gapNext   = gapCnt;
        lastNext  = lastOwner;
        unique case (state)
            INIT: begin
                stateNext = IDLE;
            end
            IDLE: begin
                if (found) begin
                    for (int i = 0; i < NUM_CH; i++) begin
                        gntNext[i] = (winIdx == 3'(i));
                    end
                    selNext   = winIdx;
                    busyNext  = 1'b1;
                    lastNext  = winIdx;
                    stateNext = GRANT;
                end
            end
            GRANT: begin
                // No preemption: other requesters are ignored here.
                if (!ownerReq) begin
                    gntNext  = '0;
                    selNext  = '0;
                    busyNext = 1'b0;
                    if (GAP_CYCLES > 0) begin
                        gapNext   = 4'(GAP_CYCLES);
                        stateNext = GAP;
                    end else begin
                        stateNext = IDLE;
                    end
                end
            end
            GAP: begin
                // Entered with the full count; the edge that takes it
                // to zero also returns to IDLE, so gnt is held low for
                // exactly GAP_CYCLES cycles before the IDLE evaluation.
                gapNext = gapCnt - 4'd1;
                if (gapCnt <= 4'd1) begin
                    gapNext   = '0;
                    stateNext = IDLE;
                end
            end
            default: begin
                stateNext = INIT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= INIT;
            gntQ      <= '0;
            selQ      <= '0;
            busyQ     <= 1'b0;
            gapCnt    <= '0;
            lastOwner <= 3'(NUM_CH - 1);
        end else begin
            state     <= stateNext;
            gntQ      <= gntNext;
            selQ      <= selNext;
            busyQ     <= busyNext;
            gapCnt    <= gapNext;
            lastOwner <= lastNext;
        end
    end

    // Port mux is purely combinational off the registered owner, so
    // the owner's live wen/data/cntl pass straight through.
    always_comb begin
        port_wen  = 1'b0;
        port_data = '0;
        port_cntl = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (busyQ && selQ == 3'(i)) begin
                port_wen  = wen[i];
                port_data = data[i*DATA_W +: DATA_W];
                port_cntl = cntl[i*CNTL_W +: CNTL_W];
            end
        end
    end

    assign gnt     = gntQ;
    assign sel_idx = selQ;
    assign busy    = busyQ;

endmodule

// File: tb/tb_hc_tx_port_arb_n.sv
// tb_hc_tx_port_arb_n: checks hc_tx_port_arb_n in fixed, round-robin
// and gap configurations with a vector table plus directed sequences.

module tb_hc_tx_port_arb_n;

    logic        clk;
    logic        rst;
    logic [2:0]  reqFix;
    logic [2:0]  reqRr;
    logic [2:0]  reqGap;
    logic [2:0]  wen;
    logic [23:0] data;
    logic [23:0] cntl;

    logic [2:0]  gntFix, gntRr, gntGap;
    logic        pwFix, pwRr, pwGap;
    logic [7:0]  pdFix, pdRr, pdGap;
    logic [7:0]  pcFix, pcRr, pcGap;
    logic [2:0]  selFix, selRr, selGap;
    logic        busyFix, busyRr, busyGap;

    int nVec = 0;
    int nMis = 0;

    logic [7:0] dArr [3] = '{8'h5A, 8'hA5, 8'h3C};
    logic [7:0] cArr [3] = '{8'hC0, 8'hC1, 8'hC2};

    typedef struct {
        logic       rst;
        logic [2:0] req;
        logic [2:0] wen;
        logic [2:0] gnt;
        logic [2:0] sel;
        logic       busy;
        logic       pwen;
    } vecT;

    typedef struct {
        logic [2:0] gnt;
        logic [2:0] sel;
        logic       busy;
        logic       pwen;
        logic [7:0] pdata;
        logic [7:0] pcntl;
    } expT;

    vecT tbl [15];
    expT sb [$];

    hc_tx_port_arb_n #(.NUM_CH(3), .DATA_W(8), .CNTL_W(8),
                       .RR_MODE(0), .GAP_CYCLES(0)) dutFix (
        .clk(clk), .rst(rst), .req(reqFix), .wen(wen),
        .data(data), .cntl(cntl), .gnt(gntFix),
        .port_wen(pwFix), .port_data(pdFix), .port_cntl(pcFix),
        .sel_idx(selFix), .busy(busyFix)
    );

    hc_tx_port_arb_n #(.NUM_CH(3), .DATA_W(8), .CNTL_W(8),
                       .RR_MODE(1), .GAP_CYCLES(0)) dutRr (
        .clk(clk), .rst(rst), .req(reqRr), .wen(wen),
        .data(data), .cntl(cntl), .gnt(gntRr),
        .port_wen(pwRr), .port_data(pdRr), .port_cntl(pcRr),
        .sel_idx(selRr), .busy(busyRr)
    );

    hc_tx_port_arb_n #(.NUM_CH(3), .DATA_W(8), .CNTL_W(8),
                       .RR_MODE(0), .GAP_CYCLES(3)) dutGap (
        .clk(clk), .rst(rst), .req(reqGap), .wen(wen),
        .data(data), .cntl(cntl), .gnt(gntGap),
        .port_wen(pwGap), .port_data(pdGap), .port_cntl(pcGap),
        .sel_idx(selGap), .busy(busyGap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [39:0] act,
                         input logic [39:0] exp);
        nVec++;
        if (act !== exp) begin
            nMis++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulseReset();
        @(negedge clk);
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        expT e;
        expT g;
        logic [2:0] oh;
        int waited;
        int order [4] = '{0, 1, 2, 0};

        rst    = 1'b1;
        reqFix = '0;
        reqRr  = '0;
        reqGap = '0;
        wen    = '0;
        data   = {dArr[2], dArr[1], dArr[0]};
        cntl   = {cArr[2], cArr[1], cArr[0]};

        //         rst   req     wen     gnt     sel busy pwen
        tbl[0]  = '{1'b1, 3'b000, 3'b000, 3'b000, 3'd0, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 3'b110, 3'b010, 3'b000, 3'd0, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 3'b110, 3'b010, 3'b010, 3'd1, 1'b1, 1'b1};
        tbl[3]  = '{1'b0, 3'b111, 3'b010, 3'b010, 3'd1, 1'b1, 1'b1};
        tbl[4]  = '{1'b0, 3'b101, 3'b010, 3'b000, 3'd0, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 3'b101, 3'b011, 3'b001, 3'd0, 1'b1, 1'b1};
        tbl[6]  = '{1'b0, 3'b001, 3'b000, 3'b001, 3'd0, 1'b1, 1'b0};
        tbl[7]  = '{1'b0, 3'b100, 3'b001, 3'b000, 3'd0, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 3'b100, 3'b100, 3'b100, 3'd2, 1'b1, 1'b1};
        tbl[9]  = '{1'b1, 3'b100, 3'b100, 3'b000, 3'd0, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 3'b100, 3'b100, 3'b000, 3'd0, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 3'b100, 3'b000, 3'b100, 3'd2, 1'b1, 1'b0};
        tbl[12] = '{1'b0, 3'b000, 3'b111, 3'b000, 3'd0, 1'b0, 1'b0};
        tbl[13] = '{1'b0, 3'b000, 3'b111, 3'b000, 3'd0, 1'b0, 1'b0};
        tbl[14] = '{1'b0, 3'b011, 3'b111, 3'b001, 3'd0, 1'b1, 1'b1};

        for (int v = 0; v < 15; v++) begin
            @(negedge clk);
            rst    = tbl[v].rst;
            reqFix = tbl[v].req;
            wen    = tbl[v].wen;
            e.gnt   = tbl[v].gnt;
            e.sel   = tbl[v].sel;
            e.busy  = tbl[v].busy;
            e.pwen  = tbl[v].pwen;
            e.pdata = tbl[v].busy ? dArr[tbl[v].sel] : 8'h00;
            e.pcntl = tbl[v].busy ? cArr[tbl[v].sel] : 8'h00;
            sb.push_back(e);
            step();
            g = sb.pop_front();
            check($sformatf("fix_vec%0d", v),
                  {16'h0, gntFix, selFix, busyFix, pwFix, pdFix, pcFix},
                  {16'h0, g.gnt, g.sel, g.busy, g.pwen, g.pdata, g.pcntl});
        end
        reqFix = '0;

        // Round-robin: req held high, each owner drops its bit after
        // two granted cycles.
        wen = 3'b111;
        pulseReset();
        reqRr = 3'b111;
        check("rr_reset", {37'h0, gntRr}, 40'h0);
        step();
        check("rr_init", {37'h0, gntRr}, 40'h0);
        for (int n = 0; n < 4; n++) begin
            oh = 3'b001 << order[n];
            waited = 0;
            while (gntRr == 3'b000 && waited < 6) begin
                step();
                waited++;
            end
            check($sformatf("rr_latency%0d", n), 40'(waited), 40'd1);
            check($sformatf("rr_order%0d", n),
                  {34'h0, gntRr, selRr}, {34'h0, oh, 3'(order[n])});
            check($sformatf("rr_pdata%0d", n),
                  {32'h0, pdRr}, {32'h0, dArr[order[n]]});
            step();
            check($sformatf("rr_hold%0d", n), {37'h0, gntRr}, {37'h0, oh});
            reqRr = 3'b111 & ~oh;
            step();
            check($sformatf("rr_release%0d", n),
                  {36'h0, gntRr, busyRr}, 40'h0);
            reqRr = 3'b111;
        end
        reqRr = '0;

        // Gap: channel 0 releases while channel 2 keeps requesting.
        pulseReset();
        reqGap = 3'b001;
        step();
        check("gap_init", {37'h0, gntGap}, 40'h0);
        step();
        check("gap_grant0", {37'h0, gntGap}, 40'h1);
        reqGap = 3'b100;
        for (int k = 0; k < 4; k++) begin
            step();
            check($sformatf("gap_idle%0d", k),
                  {32'h0, gntGap, busyGap, pwGap, 3'b000}, 40'h0);
        end
        step();
        check("gap_grant2", {34'h0, gntGap, selGap}, {34'h0, 3'b100, 3'd2});
        check("gap_pcntl", {32'h0, pcGap}, {32'h0, cArr[2]});

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

endmodule
